// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl
// ---------------
// Sequences single read/write requests onto a downstream single-port RAM
// that has a one-cycle synchronous read. Each accepted request runs
// IDLE -> ISSUE -> (CAPTURE) -> RESP and produces exactly one response.
// Only one transaction is outstanding at a time.
//
// Optional feature: define RAM_ACCESS_BOUNDS_CHECK_EN to range-check the
// signed request index against ram_len. An out-of-range request bypasses
// the RAM and is answered with rsp_err=1. Without the macro, every request
// goes to the RAM and rsp_err stays 0.
//
// Ports
//   clk        clock; all state changes on the rising edge
//   rst        synchronous active-low reset
//   req_valid  request present             req_ready  accepting (IDLE only)
//   req_write  1 = write, 0 = read         req_index  signed list index
//   req_data   write data
//   rsp_valid  response present            rsp_ready  response consumed
//   rsp_data   read data (0 for writes and errors)
//   rsp_err    index out of range
//   ram_addr/ram_d/ram_we  RAM command, driven only during ISSUE
//   ram_q      RAM read data (valid the cycle after ISSUE)
//   ram_len    number of valid RAM entries

module ram_access_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_index,
    input  logic [DATA_WIDTH-1:0] req_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_d,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_q,
    input  logic [ADDR_WIDTH-1:0] ram_len
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic                    write_q, write_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;      // registered index, drives ram_addr
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;    // registered data, drives ram_d
    logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic                    rsp_err_q, rsp_err_d;
    logic                    in_range;

`ifdef RAM_ACCESS_BOUNDS_CHECK_EN
    // One extra bit so that -ram_len and ram_len are both representable.
    logic signed [ADDR_WIDTH:0] index_ext;
    logic signed [ADDR_WIDTH:0] len_ext;

    assign index_ext = $signed({req_index[ADDR_WIDTH-1], req_index});
    assign len_ext   = $signed({1'b0, ram_len});
    assign in_range  = (index_ext < len_ext) && (index_ext >= -len_ext);
`else
    // The RAM resolves the index itself; ram_len is not needed here.
    logic unused_ram_len;

    assign unused_ram_len = ^ram_len;
    assign in_range       = 1'b1;
`endif

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case statement can leave a latch behind.
        state_d    = state_q;
        write_d    = write_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d    = req_write;
                    rsp_data_d = '0;
                    rsp_err_d  = !in_range;
                    if (in_range) begin
                        // The RAM command registers only change for requests
                        // that actually reach the RAM.
                        addr_d  = req_index;
                        wdata_d = req_data;
                        state_d = ISSUE;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            ISSUE:   state_d = write_q ? RESP : CAPTURE;
            CAPTURE: begin
                rsp_data_d = ram_q;
                state_d    = RESP;
            end
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst) begin
            state_q    <= IDLE;
            write_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            write_q    <= write_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign ram_addr  = addr_q;
    assign ram_d     = wdata_q;
    // Gated with rst so a write caught in ISSUE by reset never lands in the
    // RAM on the reset edge itself.
    assign ram_we    = (state_q == ISSUE) && write_q && rst;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Directed self-checking bench for ram_access_ctrl with ADDR_WIDTH=5 and a
// behavioural single-port RAM (ram_len=10, synchronous read, negative
// indices resolved by adding ram_len). Inputs change and outputs are
// sampled 1 time unit after the rising edge.

module tb_ram_access_ctrl;

    localparam int DW = 8;
    localparam int AW = 5;
    localparam int LEN = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_index;
    logic [DW-1:0] req_data;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_d;
    logic          ram_we;
    logic [DW-1:0] ram_q;
    logic [AW-1:0] ram_len;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ram_access_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_index(req_index), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .ram_addr(ram_addr), .ram_d(ram_d), .ram_we(ram_we),
        .ram_q(ram_q), .ram_len(ram_len)
    );

    // Behavioural RAM
    logic [DW-1:0] mem [32];

    function automatic int phys(input logic [AW-1:0] a);
        int s;
        s = $signed(a);
        if (s < 0) s = s + LEN;
        return s & 31;
    endfunction

    always @(posedge clk) begin
        if (ram_we) mem[phys(ram_addr)] <= ram_d;
        ram_q <= mem[phys(ram_addr)];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Presents one request from IDLE, then waits (bounded) for rsp_valid.
    // lat counts edges from the acceptance edge (acceptance edge = 1);
    // 0 means no response within the budget.
    task automatic run_req(input logic w, input logic [AW-1:0] idx, input logic [DW-1:0] d,
                           output int lat, output logic we_seen,
                           output logic [AW-1:0] issue_addr, output logic [DW-1:0] issue_d);
        req_valid = 1'b1;
        req_write = w;
        req_index = idx;
        req_data  = d;
        @(posedge clk); #1;
        req_valid  = 1'b0;
        issue_addr = ram_addr;
        issue_d    = ram_d;
        we_seen    = 1'b0;
        lat        = 0;
        for (int i = 1; i <= 20; i++) begin
            if (ram_we) we_seen = 1'b1;
            if (rsp_valid) begin
                lat = i;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic finish_rsp(output logic [DW-1:0] data, output logic err);
        data      = rsp_data;
        err       = rsp_err;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    int            lat;
    logic          we_seen;
    logic [AW-1:0] iaddr;
    logic [DW-1:0] idata;
    logic [DW-1:0] rdata;
    logic          rerr;

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = '0;
        rst       = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_index = '0;
        req_data  = '0;
        rsp_ready = 1'b0;
        ram_len   = AW'(LEN);
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        check("rst_req_ready", req_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_ram_we",    ram_we,    0);
        check("rst_ram_addr",  ram_addr,  0);
        check("rst_ram_d",     ram_d,     0);
        check("rst_rsp_data",  rsp_data,  0);
        check("rst_rsp_err",   rsp_err,   0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Write index 3 = 0x5A, then read it back
        run_req(1'b1, 5'd3, 8'h5A, lat, we_seen, iaddr, idata);
        check("wr3_latency",   lat,     2);
        check("wr3_issue_addr", iaddr,  5'd3);
        check("wr3_issue_d",   idata,   8'h5A);
        check("wr3_we_seen",   we_seen, 1);
        finish_rsp(rdata, rerr);
        check("wr3_rsp_data",  rdata,   0);
        check("wr3_rsp_err",   rerr,    0);
        check("wr3_idle_after", req_ready, 1);

        run_req(1'b0, 5'd3, 8'h00, lat, we_seen, iaddr, idata);
        check("rd3_latency",   lat,     3);
        check("rd3_we_seen",   we_seen, 0);
        finish_rsp(rdata, rerr);
        check("rd3_rsp_data",  rdata,   8'h5A);
        check("rd3_rsp_err",   rerr,    0);

        // Write index -1 = 0xC3, read index 9 (same physical entry)
        run_req(1'b1, 5'b11111, 8'hC3, lat, we_seen, iaddr, idata);
        check("wrm1_latency",  lat,     2);
        check("wrm1_issue_addr", iaddr, 5'b11111);
        finish_rsp(rdata, rerr);
        run_req(1'b0, 5'd9, 8'h00, lat, we_seen, iaddr, idata);
        check("rd9_latency",   lat,     3);
        finish_rsp(rdata, rerr);
        check("rd9_rsp_data",  rdata,   8'hC3);

        // Out-of-range reads: index 10 and index -11
`ifdef RAM_ACCESS_BOUNDS_CHECK_EN
        run_req(1'b0, 5'd10, 8'h00, lat, we_seen, iaddr, idata);
        check("rd10_latency",  lat,     1);
        check("rd10_we_seen",  we_seen, 0);
        finish_rsp(rdata, rerr);
        check("rd10_rsp_err",  rerr,    1);
        check("rd10_rsp_data", rdata,   0);
        run_req(1'b0, 5'b10101, 8'h00, lat, we_seen, iaddr, idata);
        check("rdm11_latency", lat,     1);
        check("rdm11_we_seen", we_seen, 0);
        finish_rsp(rdata, rerr);
        check("rdm11_rsp_err", rerr,    1);
        check("rdm11_rsp_data", rdata,  0);
        // Boundary: -10 is still in range
        run_req(1'b0, 5'b10110, 8'h00, lat, we_seen, iaddr, idata);
        check("rdm10_latency", lat,     3);
        finish_rsp(rdata, rerr);
        check("rdm10_rsp_err", rerr,    0);
`else
        run_req(1'b0, 5'd10, 8'h00, lat, we_seen, iaddr, idata);
        check("rd10_latency",  lat,     3);
        check("rd10_issue_addr", iaddr, 5'd10);
        finish_rsp(rdata, rerr);
        check("rd10_rsp_err",  rerr,    0);
        run_req(1'b0, 5'b10101, 8'h00, lat, we_seen, iaddr, idata);
        check("rdm11_latency", lat,     3);
        check("rdm11_issue_addr", iaddr, 5'b10101);
        finish_rsp(rdata, rerr);
        check("rdm11_rsp_err", rerr,    0);
`endif

        // Backpressure: hold rsp_ready low for 5 cycles in RESP
        run_req(1'b0, 5'd3, 8'h00, lat, we_seen, iaddr, idata);
        check("bp_latency", lat, 3);
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid", rsp_valid, 1);
            check("bp_rsp_data",  rsp_data,  8'h5A);
            check("bp_req_ready", req_ready, 0);
            @(posedge clk); #1;
        end
        finish_rsp(rdata, rerr);
        check("bp_rsp_data_final", rdata, 8'h5A);
        check("bp_done_valid",     rsp_valid, 0);
        check("bp_done_ready",     req_ready, 1);

        // Reset during ISSUE of a write to index 2
        run_req(1'b1, 5'd2, 8'h77, lat, we_seen, iaddr, idata);
        finish_rsp(rdata, rerr);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_index = 5'd2;
        req_data  = 8'h11;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("rstmid_issue_we", ram_we, 1);
        rst = 1'b0;
        #1;
        check("rstmid_we_gated", ram_we, 0);
        @(posedge clk); #1;
        check("rstmid_ram_we",    ram_we,    0);
        check("rstmid_rsp_valid", rsp_valid, 0);
        check("rstmid_req_ready", req_ready, 1);
        check("rstmid_ram_addr",  ram_addr,  0);
        check("rstmid_ram_d",     ram_d,     0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rstmid_no_rsp", rsp_valid, 0);
        run_req(1'b0, 5'd2, 8'h00, lat, we_seen, iaddr, idata);
        check("rstmid_rd_latency", lat, 3);
        finish_rsp(rdata, rerr);
        check("rstmid_rd_data", rdata, 8'h77);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ram_access_ctrl.md
RAM_ACCESS_CTRL -- requirements
Module: ram_access_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, the RAM word width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 4, the width of index, address and length.
REQ-003 Port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-low (rst==0 resets on the next rising clk edge).
REQ-005 Port req_valid, input, 1: request present.
REQ-006 Port req_ready, output, 1: request accepted when req_valid and req_ready are both high at a clk edge.
REQ-007 Port req_write, input, 1: 1 means write, 0 means read.
REQ-008 Port req_index, input, ADDR_WIDTH: signed list index; negative values count from the end.
REQ-009 Port req_data, input, DATA_WIDTH: write data.
REQ-010 Port rsp_valid, output, 1: response present.
REQ-011 Port rsp_ready, input, 1: response consumed when rsp_valid and rsp_ready are both high at a clk edge.
REQ-012 Port rsp_data, output, DATA_WIDTH: read data; 0 for writes and errors.
REQ-013 Port rsp_err, output, 1: index out of range.
REQ-014 Ports ram_addr (output, ADDR_WIDTH), ram_d (output, DATA_WIDTH), ram_we (output, 1), ram_q (input, DATA_WIDTH) and ram_len (input, ADDR_WIDTH) SHALL connect directly to the same-named ports of the downstream single-port RAM.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, ISSUE, CAPTURE, RESP.
REQ-016 req_ready SHALL be 1 only in IDLE.
REQ-017 On acceptance, the block SHALL register write, index and data.
  - In-range request: next state ISSUE.
  - Out-of-range request (with REQ-026 enabled): next state RESP with rsp_err=1.
REQ-018 In ISSUE (exactly one cycle):
  - ram_addr SHALL equal the registered index, passed unmodified because the RAM resolves negative indices.
  - ram_d SHALL equal the registered data.
  - ram_we SHALL equal the registered write bit.
  - Next state: CAPTURE for a read, RESP for a write.
REQ-019 In CAPTURE, the block SHALL register ram_q into rsp_data; next state RESP.
REQ-020 In RESP, rsp_valid SHALL be 1 and rsp_data/rsp_err SHALL be held stable until rsp_ready; on the handshake edge, next state IDLE.
REQ-021 Latency from the acceptance edge to first rsp_valid:
  - read: 3 cycles
  - write: 2 cycles
  - error: 1 cycle
REQ-022 ram_we SHALL be 0 in every state except ISSUE; ram_addr and ram_d SHALL hold their last values outside ISSUE.
REQ-023 A new request SHALL not be accepted in the same cycle a response completes; at most one transaction is outstanding.

Reset
REQ-024 While rst==0 at a clk edge, the block SHALL go to IDLE with rsp_valid=0, rsp_data=0, rsp_err=0, ram_we=0, ram_addr=0 and ram_d=0, including mid-transaction.
REQ-025 A transaction aborted by reset SHALL produce no response, and no RAM write SHALL occur in the reset cycle.

Configuration
REQ-026 With macro RAM_ACCESS_BOUNDS_CHECK_EN defined, an index is in range only when -ram_len <= req_index < ram_len (signed compare, widened by one bit to avoid overflow); an out-of-range request SHALL skip the RAM entirely and respond with rsp_err=1.
REQ-027 Without RAM_ACCESS_BOUNDS_CHECK_EN, every request SHALL be treated as in range and rsp_err SHALL be constant 0.

Verification
All scenarios use ADDR_WIDTH=5 and ram_len=10.
REQ-028 Write index 3 with data 0x5A, then read index 3 -> write response after 2 cycles, then rsp_data=0x5A after 3 cycles, rsp_err=0.
REQ-029 Write index -1 with data 0xC3, then read index 9 -> rsp_data=0xC3; ram_addr in ISSUE is 5'b11111.
REQ-030 Read index 10, and read index -11, with RAM_ACCESS_BOUNDS_CHECK_EN defined -> rsp_err=1 after 1 cycle, rsp_data=0, ram_we never asserted; without the macro, ISSUE is reached with no error.
REQ-031 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rsp_data remain stable and req_ready=0 throughout; response completes on the first rsp_ready=1 edge.
REQ-032 Drive rst=0 during ISSUE of a write to index 2 with data 0x11 -> ram_we=0 on the next cycle, state IDLE, no response; a later read of index 2 returns the pre-reset contents.
